// File: rtl/result_bcd_capture.sv
// Captures the calculator result written to RESULT_ADDR and converts its magnitude to ten BCD
// digits by sequential double-dabble, presenting the result until the display acknowledges it.
module result_bcd_capture #(
  parameter logic [31:0] RESULT_ADDR = 32'h0000000C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        bcd_ack,
  output logic [39:0] bcd_digits,
  output logic        negative,
  output logic        bcd_valid,
  output logic        busy,
  output logic        drop_pulse
);

  typedef enum logic [1:0] {StIdle, StConvert, StHold} state_e;

  state_e      state_q;
  logic [31:0] mag_q;
  logic        sign_q;
  logic [39:0] work_q;
  logic [4:0]  cnt_q;
  logic [31:0] pend_q;
  logic        pend_valid_q;

  logic        capture;
  logic [31:0] start_word;
  logic [39:0] work_next;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  // One double-dabble iteration: correct each digit >= 5, then shift in the next magnitude bit.
  function automatic logic [39:0] dabble_step(input logic [39:0] bcd, input logic bit_in);
    logic [39:0] adj;
    adj = bcd;
    for (int i = 0; i < 10; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return {adj[38:0], bit_in};
  endfunction

  assign capture    = mem_write && (mem_addr == RESULT_ADDR);
  // A fresh capture always beats the pending value when a new conversion starts.
  assign start_word = capture ? mem_wdata : pend_q;
  assign work_next  = dabble_step(work_q, mag_q[31]);
  assign busy       = (state_q != StIdle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      mag_q        <= '0;
      sign_q       <= 1'b0;
      work_q       <= '0;
      cnt_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      bcd_digits   <= '0;
      negative     <= 1'b0;
      bcd_valid    <= 1'b0;
      drop_pulse   <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (capture) begin
            sign_q  <= start_word[31];
            mag_q   <= abs32(start_word);
            work_q  <= '0;
            cnt_q   <= '0;
            state_q <= StConvert;
          end
        end
        StConvert: begin
          work_q <= work_next;
          mag_q  <= mag_q << 1;
          cnt_q  <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            bcd_digits <= work_next;
            negative   <= sign_q;
            bcd_valid  <= 1'b1;
            state_q    <= StHold;
          end
          if (capture) begin
            pend_q       <= mem_wdata;
            pend_valid_q <= 1'b1;
            drop_pulse   <= pend_valid_q;
          end
        end
        StHold: begin
          if (bcd_ack) begin
            bcd_valid <= 1'b0;
            if (capture || pend_valid_q) begin
              sign_q       <= start_word[31];
              mag_q        <= abs32(start_word);
              work_q       <= '0;
              cnt_q        <= '0;
              pend_valid_q <= 1'b0;
              drop_pulse   <= capture && pend_valid_q;
              state_q      <= StConvert;
            end else begin
              state_q <= StIdle;
            end
          end else if (capture) begin
            pend_q       <= mem_wdata;
            pend_valid_q <= 1'b1;
            drop_pulse   <= pend_valid_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_result_bcd_capture.sv
// Scoreboard bench for result_bcd_capture: expected BCD results are queued at capture time and
// compared when bcd_valid rises, alongside latency, drop-pulse, hold and reset checks.
module tb_result_bcd_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        bcd_ack;
  logic [39:0] bcd_digits;
  logic        negative;
  logic        bcd_valid;
  logic        busy;
  logic        drop_pulse;

  logic [40:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  result_bcd_capture #(.RESULT_ADDR(32'h0000000C)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .bcd_ack    (bcd_ack),
    .bcd_digits (bcd_digits),
    .negative   (negative),
    .bcd_valid  (bcd_valid),
    .busy       (busy),
    .drop_pulse (drop_pulse)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decimal reference by repeated division, independent of the shift-and-add method.
  function automatic logic [39:0] to_bcd(input logic [31:0] v);
    logic [39:0] r;
    logic [31:0] t;
    r = '0;
    t = v;
    for (int i = 0; i < 10; i++) begin
      r[4*i +: 4] = 4'(t % 32'd10);
      t = t / 32'd10;
    end
    return r;
  endfunction

  task automatic push_exp(input logic [31:0] v);
    logic [31:0] m;
    m = v[31] ? (32'd0 - v) : v;
    exp_q.push_back({v[31], to_bcd(m)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    mem_write = 1'b1;
    mem_addr  = addr;
    mem_wdata = data;
    tick();
    mem_write = 1'b0;
  endtask

  task automatic ack();
    bcd_ack = 1'b1;
    tick();
    bcd_ack = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int lat);
    int cyc;
    logic [40:0] e;
    cyc = 0;
    while (!bcd_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    check_eq({tag, "_latency"}, 64'(cyc), 64'(lat));
    check_eq({tag, "_sb_nonempty"}, 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq({tag, "_digits"}, 64'(bcd_digits), 64'(e[39:0]));
      check_eq({tag, "_negative"}, 64'(negative), 64'(e[40]));
    end
  endtask

  initial begin
    int seen;
    reset     = 1'b1;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    bcd_ack   = 1'b0;
    #12;
    check_eq("rst_digits", 64'(bcd_digits), 64'd0);
    check_eq("rst_valid", 64'(bcd_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_drop", 64'(drop_pulse), 64'd0);
    tick();
    reset = 1'b0;
    tick();

    // Basic conversion, hold stability and retention after ack.
    write_word(32'h0C, 32'd15);
    push_exp(32'd15);
    check_eq("w15_busy", 64'(busy), 64'd1);
    wait_valid("w15", 32);
    check_eq("w15_const", 64'(bcd_digits), 64'h15);
    repeat (3) tick();
    check_eq("w15_hold_valid", 64'(bcd_valid), 64'd1);
    check_eq("w15_hold_digits", 64'(bcd_digits), 64'h15);
    check_eq("w15_hold_busy", 64'(busy), 64'd1);
    ack();
    check_eq("w15_ack_valid", 64'(bcd_valid), 64'd0);
    check_eq("w15_ack_busy", 64'(busy), 64'd0);
    check_eq("w15_retain", 64'(bcd_digits), 64'h15);

    // Negative values including the most negative word.
    write_word(32'h0C, 32'hFFFFFFFF);
    push_exp(32'hFFFFFFFF);
    wait_valid("wm1", 32);
    check_eq("wm1_const", 64'({negative, bcd_digits}), 64'h100_0000_0001);
    ack();
    write_word(32'h0C, 32'h80000000);
    push_exp(32'h80000000);
    wait_valid("wmin", 32);
    check_eq("wmin_const", 64'({negative, bcd_digits}), 64'h121_4748_3648);
    ack();

    // Writes to neighbouring addresses are ignored.
    write_word(32'h08, 32'd24);
    write_word(32'h10, 32'd24);
    check_eq("addr_ignore_busy", 64'(busy), 64'd0);
    write_word(32'h0C, 32'd24);
    push_exp(32'd24);
    wait_valid("w24", 32);
    ack();

    // Pending overwrite during conversion: 20 is dropped in favour of 30.
    write_word(32'h0C, 32'd10);
    push_exp(32'd10);
    write_word(32'h0C, 32'd20);
    check_eq("w20_drop", 64'(drop_pulse), 64'd0);
    write_word(32'h0C, 32'd30);
    check_eq("w30_drop", 64'(drop_pulse), 64'd1);
    tick();
    check_eq("w30_drop_clear", 64'(drop_pulse), 64'd0);
    push_exp(32'd30);
    wait_valid("w10", 29);
    ack();
    check_eq("pend_ack_valid", 64'(bcd_valid), 64'd0);
    check_eq("pend_ack_busy", 64'(busy), 64'd1);
    wait_valid("w30", 32);
    ack();
    check_eq("w30_idle", 64'(busy), 64'd0);

    // Ack and capture on the same HOLD edge, then with pending full.
    write_word(32'h0C, 32'd5);
    push_exp(32'd5);
    wait_valid("w5", 32);
    bcd_ack   = 1'b1;
    mem_write = 1'b1;
    mem_addr  = 32'h0C;
    mem_wdata = 32'd7;
    tick();
    bcd_ack   = 1'b0;
    mem_write = 1'b0;
    check_eq("ackw_valid", 64'(bcd_valid), 64'd0);
    check_eq("ackw_busy", 64'(busy), 64'd1);
    push_exp(32'd7);
    wait_valid("w7", 32);
    write_word(32'h0C, 32'd40);
    check_eq("w40_drop", 64'(drop_pulse), 64'd0);
    bcd_ack   = 1'b1;
    mem_write = 1'b1;
    mem_wdata = 32'd50;
    tick();
    bcd_ack   = 1'b0;
    mem_write = 1'b0;
    check_eq("w50_drop", 64'(drop_pulse), 64'd1);
    push_exp(32'd50);
    wait_valid("w50", 32);
    ack();

    // Reset in the middle of a conversion aborts it.
    write_word(32'h0C, 32'd99);
    repeat (9) tick();
    #2 reset = 1'b1;
    #1;
    check_eq("rst_mid_digits", 64'(bcd_digits), 64'd0);
    check_eq("rst_mid_valid", 64'(bcd_valid), 64'd0);
    check_eq("rst_mid_busy", 64'(busy), 64'd0);
    tick();
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      tick();
      if (bcd_valid || busy) seen++;
    end
    check_eq("rst_no_output", 64'(seen), 64'd0);
    write_word(32'h0C, 32'd123);
    push_exp(32'd123);
    wait_valid("w123", 32);
    ack();

    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
